// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
//
// Arbitrates two AXI4-Lite read masters onto one shared AXI4-Lite read slave.
// Only one read transaction is in flight at a time. A transaction moves
// through three states: IDLE (pick a winner and accept its AR), ADDR (present
// the latched address to the slave), and DATA (pass the slave R beat back to
// the owning master). When both masters request together, round-robin
// arbitration gives the grant to the master that was not granted last.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   m_axi_ar*       : per-master read-address channels (bit/slice i = master i)
//   m_axi_r*        : per-master read-data channels (bit/slice i = master i)
//   s_axi_ar*       : read-address channel to the shared memory
//   s_axi_r*        : read-data channel from the shared memory
//   grant           : one-hot owner of the current transaction, 0 when idle
//   dbg_state       : current FSM state encoding (0 IDLE, 1 ADDR, 2 DATA)
//
// Handshake semantics: on every channel a beat transfers on a rising clk edge
// where valid and ready are both high. A valid, once raised, stays high with
// stable payload until it is accepted. Ready may depend combinationally on
// valid, but valid never depends on ready.
module mem_read_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            m_axi_arvalid,
    output logic [1:0]            m_axi_arready,
    input  logic [2*ADDR_W-1:0]   m_axi_araddr,
    output logic [1:0]            m_axi_rvalid,
    input  logic [1:0]            m_axi_rready,
    output logic [2*DATA_W-1:0]   m_axi_rdata,
    output logic [3:0]            m_axi_rresp,
    output logic                  s_axi_arvalid,
    input  logic                  s_axi_arready,
    output logic [ADDR_W-1:0]     s_axi_araddr,
    output logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_rvalid,
    output logic                  s_axi_rready,
    input  logic [DATA_W-1:0]     s_axi_rdata,
    input  logic [1:0]            s_axi_rresp,
    output logic [1:0]            grant,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic [1:0]          owner_q,   owner_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic                arvalid_q, arvalid_d;
    // Index of the master that completed the most recent transaction.
    logic                last_q,    last_d;

    logic [1:0]          win_oh;
    logic                in_idle;
    logic                in_addr;
    logic                in_data;

    assign in_idle = (state_q == ST_IDLE);
    assign in_addr = (state_q == ST_ADDR);
    assign in_data = (state_q == ST_DATA);

    // Round-robin winner: a lone requester always wins; on a tie the master
    // that was not served last wins.
    always_comb begin
        win_oh = 2'b00;
        case (m_axi_arvalid)
            2'b01:   win_oh = 2'b01;
            2'b10:   win_oh = 2'b10;
            2'b11:   win_oh = last_q ? 2'b01 : 2'b10;
            default: win_oh = 2'b00;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        arvalid_d = arvalid_q;
        last_d    = last_q;
        case (state_q)
            ST_IDLE: begin
                if (|m_axi_arvalid) begin
                    owner_d   = win_oh;
                    addr_d    = win_oh[1] ? m_axi_araddr[ADDR_W +: ADDR_W]
                                          : m_axi_araddr[0 +: ADDR_W];
                    arvalid_d = 1'b1;
                    state_d   = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (s_axi_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // The round-robin pointer moves only when the R beat completes.
                if (s_axi_rvalid && s_axi_rready) begin
                    last_d  = owner_q[1];
                    owner_d = 2'b00;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Unused encoding: recover to IDLE with everything cleared.
                owner_d   = 2'b00;
                arvalid_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= 2'b00;
            addr_q    <= '0;
            arvalid_q <= 1'b0;
            last_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            addr_q    <= addr_d;
            arvalid_q <= arvalid_d;
            last_q    <= last_d;
        end
    end

    // Slave AR outputs come straight from flops, so master AR inputs never
    // reach them combinationally.
    assign s_axi_arvalid = arvalid_q & in_addr;
    assign s_axi_araddr  = addr_q;
    assign s_axi_arprot  = 3'b000;
    assign grant         = (in_addr || in_data) ? owner_q : 2'b00;
    assign dbg_state     = state_q;

    // Master-facing handshakes and the R-channel passthrough. arready is
    // gated by rst because the idle-state acceptance path is combinational.
    always_comb begin
        m_axi_arready = 2'b00;
        m_axi_rvalid  = 2'b00;
        m_axi_rdata   = '0;
        m_axi_rresp   = 4'b0000;
        s_axi_rready  = 1'b0;
        if (in_idle && !rst) begin
            m_axi_arready = win_oh;
        end
        if (in_data) begin
            m_axi_rvalid = owner_q & {2{s_axi_rvalid}};
            s_axi_rready = |(owner_q & m_axi_rready);
            for (int i = 0; i < 2; i++) begin
                if (owner_q[i]) begin
                    m_axi_rdata[i*DATA_W +: DATA_W] = s_axi_rdata;
                    m_axi_rresp[2*i +: 2]           = s_axi_rresp;
                end
            end
        end
    end

endmodule
